// File: rtl/sim_boot_ctrl.sv
// ---------------------------------------------------------------------------
// sim_boot_ctrl
//
// Boot-and-monitor controller for the single-cycle RV core simulation top.
// It streams a program image into instruction memory one word per accepted
// beat while the core is held. It then pulses pc_load for one cycle and
// releases the core. While the core runs, it snoops data stores: a store to
// TOHOST_ADDR ends the run with pass or fail, and an optional cycle budget
// ends it with a timeout. From DONE, a rearm request starts the next image
// load, so one simulation can run several programs.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   ld_valid/ready    image beat handshake; a beat is accepted on valid&ready
//   ld_data, ld_last  instruction word and final-beat marker
//   imem_we/waddr/    registered instruction-memory write port; it is valid
//   imem_wdata        in the cycle after a beat is accepted
//   cpu_hold          freezes the core (no PC update, no stores) when 1
//   pc_load, pc_init  one-cycle PC-load strobe and the constant start PC
//   mon_we/addr/wdata snooped core data-store bus
//   rearm             restart request; honoured only in DONE
//   done, status      sticky completion flag and result code:
//                     0 busy, 1 pass, 2 fail, 3 timeout, 4 load overflow
//   fail_code         tohost value shifted right by one, on fail
//   cycle_count       number of RUN cycles elapsed; saturates at 2^32-1
// ---------------------------------------------------------------------------
module sim_boot_ctrl #(
  parameter int unsigned      XLEN        = 32,
  parameter int unsigned      IMEM_DEPTH  = 1024,
  parameter logic [XLEN-1:0]  RESET_PC    = 32'h0,
  parameter logic [XLEN-1:0]  TOHOST_ADDR = 32'h0000_1000,
  parameter int unsigned      TIMEOUT     = 100000,
  localparam int unsigned     AW          = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  // image stream
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [31:0]     ld_data,
  input  logic            ld_last,
  // instruction-memory write port
  output logic            imem_we,
  output logic [AW-1:0]   imem_waddr,
  output logic [31:0]     imem_wdata,
  // core control
  output logic            cpu_hold,
  output logic            pc_load,
  output logic [XLEN-1:0] pc_init,
  // store snoop
  input  logic            mon_we,
  input  logic [XLEN-1:0] mon_addr,
  input  logic [XLEN-1:0] mon_wdata,
  // run control and result
  input  logic            rearm,
  output logic            done,
  output logic [2:0]      status,
  output logic [XLEN-1:0] fail_code,
  output logic [31:0]     cycle_count
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] STAT_BUSY     = 3'd0;
  localparam logic [2:0] STAT_PASS     = 3'd1;
  localparam logic [2:0] STAT_FAIL     = 3'd2;
  localparam logic [2:0] STAT_TIMEOUT  = 3'd3;
  localparam logic [2:0] STAT_OVERFLOW = 3'd4;

  // The last writable word address. A non-final beat accepted here fills
  // the memory, so the load ends with an overflow result.
  localparam logic [AW-1:0]   LAST_ADDR    = AW'(IMEM_DEPTH - 32'd1);
  localparam logic [XLEN-1:0] TOHOST_PASS  = XLEN'(1'b1);
  localparam logic [31:0]     CNT_MAX      = 32'hFFFF_FFFF;
  localparam logic            TIMEOUT_EN   = (TIMEOUT != 32'd0);
  // The count is compared against TIMEOUT-1 and incremented in the same
  // cycle, so DONE shows exactly TIMEOUT elapsed RUN cycles.
  localparam logic [31:0]     TIMEOUT_LAST = (TIMEOUT == 32'd0) ? 32'd0 : (TIMEOUT - 32'd1);

  state_t            state_r;
  state_t            state_s;
  logic [AW-1:0]     wptr_r;
  logic [AW-1:0]     wptr_s;
  logic [2:0]        status_r;
  logic [2:0]        status_s;
  logic [XLEN-1:0]   fail_code_r;
  logic [XLEN-1:0]   fail_code_s;
  logic [31:0]       cycle_count_r;
  logic [31:0]       cycle_count_s;
  logic              accept_s;
  logic              tohost_hit_s;

  logic              imem_we_r;
  logic [AW-1:0]     imem_waddr_r;
  logic [31:0]       imem_wdata_r;
  logic              cpu_hold_r;
  logic              pc_load_r;
  logic              done_r;

  // Image beats are accepted in LOAD only. This path is combinational from
  // the state so that a beat can be accepted on every cycle.
  assign ld_ready     = (state_r == ST_LOAD);
  assign accept_s     = ld_valid & ld_ready;
  assign tohost_hit_s = mon_we & (mon_addr == TOHOST_ADDR);

  // Next-state, write-pointer, result and cycle-counter logic
  always_comb begin
    state_s       = state_r;
    wptr_s        = wptr_r;
    status_s      = status_r;
    fail_code_s   = fail_code_r;
    cycle_count_s = cycle_count_r;
    case (state_r)
      ST_LOAD: begin
        if (accept_s) begin
          wptr_s = wptr_r + AW'(1'b1);
          if (ld_last) begin
            state_s = ST_START;
          end else if (wptr_r == LAST_ADDR) begin
            state_s  = ST_DONE;
            status_s = STAT_OVERFLOW;
          end else begin
            state_s = ST_LOAD;
          end
        end else begin
          wptr_s = wptr_r;
        end
      end
      ST_START: begin
        state_s = ST_RUN;
      end
      ST_RUN: begin
        // The terminating cycle is counted too.
        if (cycle_count_r == CNT_MAX) begin
          cycle_count_s = cycle_count_r;
        end else begin
          cycle_count_s = cycle_count_r + 32'd1;
        end
        // A tohost store takes priority over a timeout in the same cycle.
        if (tohost_hit_s) begin
          state_s = ST_DONE;
          if (mon_wdata == TOHOST_PASS) begin
            status_s = STAT_PASS;
          end else begin
            status_s    = STAT_FAIL;
            fail_code_s = mon_wdata >> 1;
          end
        end else if (TIMEOUT_EN && (cycle_count_r == TIMEOUT_LAST)) begin
          state_s  = ST_DONE;
          status_s = STAT_TIMEOUT;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        // Results stay sticky until rearm. Stores seen here are ignored.
        if (rearm) begin
          state_s       = ST_LOAD;
          wptr_s        = '0;
          status_s      = STAT_BUSY;
          fail_code_s   = '0;
          cycle_count_s = 32'd0;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_LOAD;
      end
    endcase
  end

  // State, write pointer and run-result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_LOAD;
      wptr_r        <= '0;
      status_r      <= STAT_BUSY;
      fail_code_r   <= '0;
      cycle_count_r <= 32'd0;
    end else begin
      state_r       <= state_s;
      wptr_r        <= wptr_s;
      status_r      <= status_s;
      fail_code_r   <= fail_code_s;
      cycle_count_r <= cycle_count_s;
    end
  end

  // Registered instruction-memory write port, one cycle behind acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_we_r    <= 1'b0;
      imem_waddr_r <= '0;
      imem_wdata_r <= 32'd0;
    end else begin
      imem_we_r <= accept_s;
      if (accept_s) begin
        imem_waddr_r <= wptr_r;
        imem_wdata_r <= ld_data;
      end
    end
  end

  // Core-control and done flags. They are registered from the next state,
  // so each flag changes on the same edge as the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_hold_r <= 1'b1;
      pc_load_r  <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      cpu_hold_r <= (state_s != ST_RUN);
      pc_load_r  <= (state_s == ST_START);
      done_r     <= (state_s == ST_DONE);
    end
  end

  assign imem_we     = imem_we_r;
  assign imem_waddr  = imem_waddr_r;
  assign imem_wdata  = imem_wdata_r;
  assign cpu_hold    = cpu_hold_r;
  assign pc_load     = pc_load_r;
  assign pc_init     = RESET_PC;
  assign done        = done_r;
  assign status      = status_r;
  assign fail_code   = fail_code_r;
  assign cycle_count = cycle_count_r;

endmodule

// File: tb/tb_sim_boot_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sim_boot_ctrl
//
// Self-checking bench for sim_boot_ctrl (IMEM_DEPTH=4, TIMEOUT=10).
// Each accepted image beat pushes its expected {address, data} write onto a
// queue. A negedge monitor pops that queue whenever the DUT writes to
// instruction memory. Run results are checked against constants that
// follow from each scenario.
// ---------------------------------------------------------------------------
module tb_sim_boot_ctrl;

  localparam int TB_AW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              ld_valid;
  logic              ld_ready;
  logic [31:0]       ld_data;
  logic              ld_last;
  logic              imem_we;
  logic [TB_AW-1:0]  imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              pc_load;
  logic [31:0]       pc_init;
  logic              mon_we;
  logic [31:0]       mon_addr;
  logic [31:0]       mon_wdata;
  logic              rearm;
  logic              done;
  logic [2:0]        status;
  logic [31:0]       fail_code;
  logic [31:0]       cycle_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_push   = 0;
  int n_wr     = 0;
  int m_wptr   = 0;

  logic [TB_AW+31:0] exp_q[$];
  logic [TB_AW+31:0] exp_e;
  logic [31:0]       img[5];

  sim_boot_ctrl #(
    .XLEN(32),
    .IMEM_DEPTH(4),
    .RESET_PC(32'h0),
    .TOHOST_ADDR(32'h0000_1000),
    .TIMEOUT(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_data(ld_data),
    .ld_last(ld_last),
    .imem_we(imem_we),
    .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold),
    .pc_load(pc_load),
    .pc_init(pc_init),
    .mon_we(mon_we),
    .mon_addr(mon_addr),
    .mon_wdata(mon_wdata),
    .rearm(rearm),
    .done(done),
    .status(status),
    .fail_code(fail_code),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every instruction-memory write must match the oldest
  // outstanding accepted beat.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        check_eq("wr_unexp", 64'(imem_we), 64'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check_eq("wr_addr", 64'(imem_waddr), 64'(exp_e[TB_AW+31:32]));
        check_eq("wr_data", 64'(imem_wdata), 64'(exp_e[31:0]));
      end
    end
  end

  task automatic check_reset_vals(input string p);
    check_eq({p, "_ld_ready"},    64'(ld_ready),    64'd1);
    check_eq({p, "_cpu_hold"},    64'(cpu_hold),    64'd1);
    check_eq({p, "_imem_we"},     64'(imem_we),     64'd0);
    check_eq({p, "_imem_waddr"},  64'(imem_waddr),  64'd0);
    check_eq({p, "_imem_wdata"},  64'(imem_wdata),  64'd0);
    check_eq({p, "_pc_load"},     64'(pc_load),     64'd0);
    check_eq({p, "_pc_init"},     64'(pc_init),     64'd0);
    check_eq({p, "_done"},        64'(done),        64'd0);
    check_eq({p, "_status"},      64'(status),      64'd0);
    check_eq({p, "_fail_code"},   64'(fail_code),   64'd0);
    check_eq({p, "_cycle_count"}, 64'(cycle_count), 64'd0);
  endtask

  // Stream n words with ld_valid held high and last on the final word, then
  // check the START cycle and the first RUN cycle.
  task automatic load_image(input int n);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = img[i];
      ld_last  = (i == n - 1);
      check_eq("ld_ready_load", 64'(ld_ready), 64'd1);
      exp_q.push_back({TB_AW'(m_wptr), img[i]});
      n_push++;
      m_wptr++;
      step();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_data  = 32'd0;
    check_eq("start_pc_load",  64'(pc_load),  64'd1);
    check_eq("start_cpu_hold", 64'(cpu_hold), 64'd1);
    check_eq("start_pc_init",  64'(pc_init),  64'd0);
    check_eq("start_ld_ready", 64'(ld_ready), 64'd0);
    step();
    check_eq("run_pc_load",  64'(pc_load),     64'd0);
    check_eq("run_cpu_hold", 64'(cpu_hold),    64'd0);
    check_eq("run_count0",   64'(cycle_count), 64'd0);
    check_eq("run_done",     64'(done),        64'd0);
  endtask

  // Wait for a given number of cycles, then drive one store for one cycle.
  task automatic run_store(input int at, input logic [31:0] addr, input logic [31:0] data);
    repeat (at) step();
    mon_we    = 1'b1;
    mon_addr  = addr;
    mon_wdata = data;
    step();
    mon_we    = 1'b0;
    mon_addr  = 32'd0;
    mon_wdata = 32'd0;
  endtask

  task automatic do_rearm();
    check_eq("rearm_pre_ready", 64'(ld_ready), 64'd0);
    rearm = 1'b1;
    step();
    rearm = 1'b0;
    check_eq("rearm_ld_ready",  64'(ld_ready),    64'd1);
    check_eq("rearm_done",      64'(done),        64'd0);
    check_eq("rearm_status",    64'(status),      64'd0);
    check_eq("rearm_fail_code", 64'(fail_code),   64'd0);
    check_eq("rearm_count",     64'(cycle_count), 64'd0);
    check_eq("rearm_cpu_hold",  64'(cpu_hold),    64'd1);
    m_wptr = 0;
  endtask

  initial begin
    img[0] = 32'h00a0_0093;
    img[1] = 32'h0140_0113;
    img[2] = 32'hffb0_0193;
    img[3] = 32'h0000_0013;
    img[4] = 32'h1234_5678;
    rst = 1'b1; ld_valid = 1'b0; ld_data = 32'd0; ld_last = 1'b0;
    mon_we = 1'b0; mon_addr = 32'd0; mon_wdata = 32'd0; rearm = 1'b0;
    #3;
    check_reset_vals("por");
    step();
    step();
    rst = 1'b0;
    check_reset_vals("post_rst");

    // Three-word image, then pass on RUN cycle 5
    load_image(3);
    run_store(5, 32'h0000_1000, 32'h0000_0001);
    check_eq("pass_done",      64'(done),        64'd1);
    check_eq("pass_status",    64'(status),      64'd1);
    check_eq("pass_count",     64'(cycle_count), 64'd6);
    check_eq("pass_cpu_hold",  64'(cpu_hold),    64'd1);
    check_eq("pass_fail_code", 64'(fail_code),   64'd0);
    // A tohost store while in DONE must not change the result
    run_store(0, 32'h0000_1000, 32'h0000_0007);
    check_eq("done_ign_status", 64'(status),      64'd1);
    check_eq("done_ign_fcode",  64'(fail_code),   64'd0);
    check_eq("done_ign_count",  64'(cycle_count), 64'd6);

    // Re-arm, shorter image, ignored store to 0x1004, then fail
    do_rearm();
    load_image(2);
    run_store(2, 32'h0000_1004, 32'h0000_0001);
    check_eq("ign1004_done", 64'(done), 64'd0);
    run_store(1, 32'h0000_1000, 32'h0000_0007);
    check_eq("fail_done",      64'(done),        64'd1);
    check_eq("fail_status",    64'(status),      64'd2);
    check_eq("fail_fail_code", 64'(fail_code),   64'd3);
    check_eq("fail_count",     64'(cycle_count), 64'd5);

    // Timeout after 10 RUN cycles; a rearm pulse mid-run must be ignored
    do_rearm();
    load_image(1);
    repeat (3) step();
    rearm = 1'b1;
    step();
    rearm = 1'b0;
    repeat (5) step();
    check_eq("to_pre_done",  64'(done),        64'd0);
    check_eq("to_pre_count", 64'(cycle_count), 64'd9);
    step();
    check_eq("to_done",      64'(done),        64'd1);
    check_eq("to_status",    64'(status),      64'd3);
    check_eq("to_count",     64'(cycle_count), 64'd10);
    check_eq("to_fail_code", 64'(fail_code),   64'd0);

    // A tohost pass on the 10th RUN cycle beats the timeout
    do_rearm();
    load_image(1);
    run_store(9, 32'h0000_1000, 32'h0000_0001);
    check_eq("tie_status", 64'(status),      64'd1);
    check_eq("tie_count",  64'(cycle_count), 64'd10);

    // Overflow: five beats, no last, depth 4
    do_rearm();
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_data  = img[i];
      ld_last  = 1'b0;
      check_eq("ovf_ld_ready", 64'(ld_ready), 64'd1);
      exp_q.push_back({TB_AW'(m_wptr), img[i]});
      n_push++;
      m_wptr++;
      step();
    end
    ld_data = img[4];
    check_eq("ovf_ready5",   64'(ld_ready), 64'd0);
    check_eq("ovf_done",     64'(done),     64'd1);
    check_eq("ovf_status",   64'(status),   64'd4);
    check_eq("ovf_cpu_hold", 64'(cpu_hold), 64'd1);
    check_eq("ovf_pc_load",  64'(pc_load),  64'd0);
    step();
    check_eq("ovf_ready5b",  64'(ld_ready), 64'd0);
    check_eq("ovf_no_write", 64'(imem_we),  64'd0);
    ld_valid = 1'b0;
    ld_data  = 32'd0;

    // Asynchronous reset mid-RUN, then reload from address 0
    do_rearm();
    load_image(1);
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_q_empty", 64'(exp_q.size()), 64'd0);
    m_wptr = 0;
    load_image(2);
    run_store(0, 32'h0000_1000, 32'h0000_0001);
    check_eq("rst_pass_status", 64'(status),      64'd1);
    check_eq("rst_pass_count",  64'(cycle_count), 64'd1);

    step();
    check_eq("wr_count",   64'(n_wr),         64'(n_push));
    check_eq("wr_pending", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
